// File: rtl/sound_pkg.sv
// Shared definitions for the sound request scheduler: FSM encoding, sound codes
// and a small constant helper.
package sound_pkg;

    localparam int CODE_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ACK   = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } sched_state_t;

    localparam logic [CODE_W-1:0] SND_NONE    = 3'd0;
    localparam logic [CODE_W-1:0] SND_MOVE    = 3'd1;
    localparam logic [CODE_W-1:0] SND_CAPTURE = 3'd2;
    localparam logic [CODE_W-1:0] SND_CHECK   = 3'd3;
    localparam logic [CODE_W-1:0] SND_WIN     = 3'd4;
    localparam logic [CODE_W-1:0] SND_CLICK   = 3'd5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sound_fifo.sv
// Synchronous FIFO of sound codes; a push into a full FIFO is accepted when a
// pop happens in the same cycle.
module sound_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_push_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // NOTE: storage has no reset; occupancy is carried entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sound_request_scheduler.sv
// Shares one tone generator among prioritised game-event requesters: pending
// latches, fixed-priority arbiter into a FIFO, and a play/ack/gap sequencer.
module sound_request_scheduler
    import sound_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CODE_W  = sound_pkg::CODE_W,
    parameter int DEPTH   = 4,
    parameter int ACK_CYC = 16,
    parameter int MAX_CYC = 1 << 24,
    parameter int GAP_CYC = 5000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*CODE_W-1:0]   req_code,
    input  logic                      snd_busy,
    output logic [CODE_W-1:0]         snd_code,
    output logic                      snd_play,
    output logic [$clog2(DEPTH):0]    q_count,
    output logic                      overwrite,
    output logic                      timeout
);

    localparam int CNT_W = $clog2(max3(ACK_CYC, MAX_CYC, GAP_CYC) + 1);
    localparam logic [CNT_W-1:0] ACK_LOAD = CNT_W'(ACK_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LOAD = CNT_W'(MAX_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC - 1);

    logic [N_REQ-1:0]  r_pend;
    logic [CODE_W-1:0] r_pend_code [N_REQ];
    logic              r_overwrite;

    logic [N_REQ-1:0]  w_grant;
    logic [N_REQ-1:0]  w_grant_en;
    logic [CODE_W-1:0] w_push_code;
    logic              w_push;
    logic              w_pop;
    logic [CODE_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;

    sched_state_t      r_state;
    sched_state_t      w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_set_timeout;
    logic [CODE_W-1:0] r_snd_code;
    logic              r_snd_play;
    logic              r_timeout;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_grant     = '0;
        w_push_code = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_pend[i] && (w_grant == '0)) begin
                w_grant[i]  = 1'b1;
                w_push_code = r_pend_code[i];
            end
        end
    end

    assign w_pop      = (r_state == ST_ISSUE);
    assign w_push     = (|r_pend) && (!w_full || w_pop);
    assign w_grant_en = w_push ? w_grant : '0;

    // A new request overrides an older one only when the older one is not leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend      <= '0;
            r_overwrite <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                r_pend_code[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_pend_code[i] <= req_code[i*CODE_W +: CODE_W];
                    if (r_pend[i] && !w_grant_en[i]) begin
                        r_overwrite <= 1'b1;
                    end
                end else if (w_grant_en[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    sound_fifo #(
        .DEPTH (DEPTH),
        .W     (CODE_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_code),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (q_count)
    );

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_next     = ST_ACK;
                w_cnt_next = ACK_LOAD;
            end
            ST_ACK: begin
                if (snd_busy) begin
                    w_next     = ST_PLAY;
                    w_cnt_next = MAX_LOAD;
                end else if (r_cnt == '0) begin
                    w_set_timeout = 1'b1;
                    w_next        = ST_GAP;
                    w_cnt_next    = GAP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_PLAY: begin
                if (!snd_busy) begin
                    w_next     = ST_GAP;
                    w_cnt_next = GAP_LOAD;
                end else if (r_cnt == '0) begin
                    w_set_timeout = 1'b1;
                    w_next        = ST_GAP;
                    w_cnt_next    = GAP_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) w_next = ST_IDLE;
                else             w_cnt_next = r_cnt - 1'b1;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // Code and strobe are loaded on entry to ISSUE so both are valid in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_snd_code <= '0;
            r_snd_play <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_snd_play <= (r_state == ST_IDLE) && (w_next == ST_ISSUE);
            if ((r_state == ST_IDLE) && (w_next == ST_ISSUE)) begin
                r_snd_code <= w_head;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign snd_code  = r_snd_code;
    assign snd_play  = r_snd_play;
    assign overwrite = r_overwrite;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_sound_request_scheduler.sv
// Directed bench for sound_request_scheduler with a behavioural Sound model
// driving snd_busy after each play strobe.
module tb_sound_request_scheduler;
    import sound_pkg::*;

    localparam int NR      = 4;
    localparam int CW      = CODE_W;
    localparam int DEPTH   = 4;
    localparam int ACK_CYC = 16;
    localparam int GAP_CYC = 40;

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic [NR-1:0]   req      = '0;
    logic [NR*CW-1:0] req_code = '0;
    logic            snd_busy = 1'b0;
    logic [CW-1:0]   snd_code;
    logic            snd_play;
    logic [$clog2(DEPTH):0] q_count;
    logic            overwrite;
    logic            timeout;

    sound_request_scheduler #(
        .N_REQ   (NR),
        .CODE_W  (CW),
        .DEPTH   (DEPTH),
        .ACK_CYC (ACK_CYC),
        .MAX_CYC (1 << 24),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_code  (req_code),
        .snd_busy  (snd_busy),
        .snd_code  (snd_code),
        .snd_play  (snd_play),
        .q_count   (q_count),
        .overwrite (overwrite),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Sound model configuration and play log
    bit            busy_en  = 1'b1;
    int            busy_dly = 3;
    int            busy_len = 100;
    logic [CW-1:0] play_code [$];
    int            play_t [$];
    int            fall_t = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (snd_play && !rst) begin
                play_code.push_back(snd_code);
                play_t.push_back(cyc);
                if (busy_en) begin
                    for (int k = 0; k < busy_dly && !rst; k++) @(negedge clk);
                    if (!rst) begin
                        snd_busy = 1'b1;
                        for (int k = 0; k < busy_len && !rst; k++) @(negedge clk);
                    end
                    snd_busy = 1'b0;
                    fall_t   = cyc;
                end
            end
        end
    end

    // Occupancy peak and strobe-width monitor
    int   qmax = 0;
    bit   qmax_clr = 1'b0;
    int   dbl = 0;
    logic prev_play = 1'b0;
    always @(negedge clk) begin
        if (qmax_clr) qmax = 0;
        else if (int'(q_count) > qmax) qmax = int'(q_count);
        if (prev_play && snd_play) dbl++;
        prev_play = snd_play;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [NR*CW-1:0] pack(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                              input logic [CW-1:0] c2, input logic [CW-1:0] c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic pulse_req(input logic [NR-1:0] r, input logic [NR*CW-1:0] codes);
        req      = r;
        req_code = codes;
        @(negedge clk);
        req      = '0;
        req_code = '0;
    endtask

    task automatic wait_plays(input int n, input int budget, input string tag);
        int k = 0;
        while (play_code.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, play_code.size(), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        play_code.delete();
        play_t.delete();
    endtask

    task automatic check_code(input string tag, input int idx, input logic [CW-1:0] exp);
        if (idx < play_code.size()) check(tag, play_code[idx], exp);
        else                        check(tag, 32'hFFFF_FFFF, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int t0;
        int s;
        int k;
        int n;
        logic [CW-1:0] exp4 [7];

        tick(3);
        check("rst_code", snd_code, 0);
        check("rst_play", snd_play, 0);
        check("rst_qcnt", q_count, 0);
        check("rst_ovw", overwrite, 0);
        check("rst_to", timeout, 0);
        rst = 1'b0;
        tick(2);

        // Single request, latency and spacing to the next sound
        t0 = cyc;
        pulse_req(4'b0010, pack(SND_NONE, SND_CAPTURE, SND_NONE, SND_NONE));
        check("t1_qcnt_t1", q_count, 0);
        @(negedge clk);
        check("t1_qcnt_t2", q_count, 1);
        wait_plays(1, 50, "t1_play1");
        check_code("t1_code1", 0, SND_CAPTURE);
        if (play_t.size() > 0) check("t1_strobe_lat", play_t[0] - t0, 3);
        tick(20);
        pulse_req(4'b1000, pack(SND_NONE, SND_NONE, SND_NONE, SND_MOVE));
        wait_plays(2, 400, "t1_play2");
        check_code("t1_code2", 1, SND_MOVE);
        if (play_t.size() > 1) begin
            check("t1_spacing", play_t[1] - play_t[0], 3 + 100 + 1 + GAP_CYC + 1);
            check("t1_gap_ok", play_t[1] >= fall_t + GAP_CYC, 1);
        end
        check("t1_ovw", overwrite, 0);
        check("t1_to", timeout, 0);

        // Simultaneous requests arrive while a sound is playing
        do_reset();
        pulse_req(4'b0100, pack(SND_NONE, SND_NONE, SND_CLICK, SND_NONE));
        wait_plays(1, 50, "t2_play1");
        tick(10);
        qmax_clr = 1'b1;
        tick(2);
        qmax_clr = 1'b0;
        pulse_req(4'b1011, pack(SND_MOVE, SND_CAPTURE, SND_NONE, SND_WIN));
        wait_plays(4, 800, "t2_plays");
        check_code("t2_code0", 0, SND_CLICK);
        check_code("t2_code1", 1, SND_MOVE);
        check_code("t2_code2", 2, SND_CAPTURE);
        check_code("t2_code3", 3, SND_WIN);
        check("t2_qmax", qmax, 3);
        check("t2_ovw", overwrite, 0);

        // Second request from a still-pending requester replaces the first
        do_reset();
        pulse_req(4'b0101, pack(SND_MOVE, SND_NONE, SND_CHECK, SND_NONE));
        pulse_req(4'b0100, pack(SND_NONE, SND_NONE, SND_CLICK, SND_NONE));
        check("t3_ovw", overwrite, 1);
        wait_plays(2, 400, "t3_plays");
        tick(200);
        check("t3_count", play_code.size(), 2);
        check_code("t3_code0", 0, SND_MOVE);
        check_code("t3_code1", 1, SND_CLICK);

        // Full FIFO with two more pending: nothing lost, order preserved
        do_reset();
        pulse_req(4'b1000, pack(SND_NONE, SND_NONE, SND_NONE, SND_CLICK));
        wait_plays(1, 50, "t4_play1");
        tick(5);
        qmax_clr = 1'b1;
        tick(2);
        qmax_clr = 1'b0;
        pulse_req(4'b1111, pack(SND_MOVE, SND_CAPTURE, SND_CHECK, SND_WIN));
        tick(5);
        pulse_req(4'b0011, pack(SND_CLICK, SND_WIN, SND_NONE, SND_NONE));
        tick(10);
        check("t4_full", q_count, 4);
        tick(20);
        check("t4_hold", q_count, 4);
        exp4 = '{SND_CLICK, SND_MOVE, SND_CAPTURE, SND_CHECK, SND_WIN, SND_CLICK, SND_WIN};
        wait_plays(7, 1500, "t4_plays");
        for (int i = 0; i < 7; i++) begin
            check_code($sformatf("t4_code%0d", i), i, exp4[i]);
        end
        check("t4_qmax", qmax, 4);

        // Generator never answers: ack timeout, then the next entry still plays
        busy_en = 1'b0;
        do_reset();
        pulse_req(4'b0011, pack(SND_CHECK, SND_WIN, SND_NONE, SND_NONE));
        wait_plays(1, 50, "t5_play1");
        s = (play_t.size() > 0) ? play_t[0] : cyc;
        k = 0;
        while (!timeout && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t5_to_lat", cyc - s, ACK_CYC + 1);
        check("t5_to", timeout, 1);
        wait_plays(2, 200, "t5_play2");
        if (play_t.size() > 1) check("t5_spacing", play_t[1] - play_t[0], 1 + ACK_CYC + GAP_CYC + 1);
        check_code("t5_code1", 1, SND_WIN);
        check("t5_to_sticky", timeout, 1);

        // Reset while playing with three entries queued
        busy_en = 1'b1;
        do_reset();
        pulse_req(4'b1111, pack(SND_MOVE, SND_CAPTURE, SND_CHECK, SND_WIN));
        wait_plays(1, 50, "t6_play1");
        tick(10);
        check("t6_qcnt_pre", q_count, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_code", snd_code, 0);
        check("t6_play", snd_play, 0);
        check("t6_qcnt", q_count, 0);
        check("t6_ovw", overwrite, 0);
        check("t6_to", timeout, 0);
        n = play_code.size();
        tick(300);
        check("t6_no_play", play_code.size(), n);
        check("t6_qcnt_post", q_count, 0);

        check("strobe_width", dbl, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
